// File: rtl/alu24_pkg.sv
// Shared opcode encoding and scheduler state type for the ALU24 datapath.
package alu24_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_MUL  = 3'b001;
  localparam logic [2:0] OP_LI   = 3'b010;
  localparam logic [2:0] OP_ADDR = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_LUI  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_MAC  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_MAC_MUL = 2'd2,
    ST_MAC_ADD = 2'd3
  } state_t;

endpackage

// File: rtl/ALU24.sv
// Combinational 24-bit ALU: wrapping add/mul, logical ops, arithmetic shift,
// zero flag and signed A<B flag.
module ALU24
  import alu24_pkg::*;
#(
  parameter int W = 24
) (
  input  logic [2:0]          i_op,
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_y,
  output logic                o_z,
  output logic                o_lt
);

  always_comb begin
    o_y = i_a;
    case (i_op)
      OP_ADD, OP_ADDR: o_y = i_a + i_b;
      OP_MUL:          o_y = i_a * i_b;  // low W bits are identical for signed/unsigned
      OP_LI, OP_LUI:   o_y = i_b;
      OP_OR:           o_y = i_a | i_b;
      OP_SHR:          o_y = i_a >>> i_b[4:0];
      OP_MAC:          o_y = i_a;
      default:         o_y = i_a;
    endcase
  end

  assign o_z  = (o_y == '0);
  assign o_lt = (i_a < i_b);

endmodule

// File: rtl/alu24_sched.sv
// Round-robin two-port scheduler sharing one ALU24; MAC runs as a multiply
// pass followed by an add pass. Responses are registered and tagged by port.
module alu24_sched
  import alu24_pkg::*;
#(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req0_c,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [W-1:0] req1_c,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [W-1:0] rsp_y,
  output logic         rsp_z,
  output logic         rsp_lt,
  output logic         busy
);

  state_t              r_state;
  logic                r_last;
  logic                r_id;
  logic [2:0]          r_op;
  logic signed [W-1:0] r_a, r_b, r_c, r_prod;
  logic                r_rsp_valid, r_rsp_id, r_rsp_z, r_rsp_lt;
  logic [W-1:0]        r_rsp_y;

  logic                w_idle, w_acc;
  logic [2:0]          w_sel_op;
  logic [2:0]          w_alu_op;
  logic signed [W-1:0] w_alu_a, w_alu_b, w_alu_y;
  logic                w_alu_z, w_alu_lt;

  // Arbitration: the port that did not win last time gets priority on a tie.
  assign w_idle     = (r_state == ST_IDLE);
  assign req0_ready = !rst && w_idle && req0_valid && (!req1_valid || r_last);
  assign req1_ready = !rst && w_idle && req1_valid && (!req0_valid || !r_last);
  assign w_acc      = req0_ready || req1_ready;
  assign w_sel_op   = req1_ready ? req1_op : req0_op;

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_id <= req1_ready;
      r_op <= w_sel_op;
      r_a  <= req1_ready ? req1_a : req0_a;
      r_b  <= req1_ready ? req1_b : req0_b;
      r_c  <= req1_ready ? req1_c : req0_c;
    end
  end

  // ALU operand steering; MAC is never handed to the ALU directly.
  always_comb begin
    w_alu_op = OP_ADD;
    w_alu_a  = '0;
    w_alu_b  = '0;
    case (r_state)
      ST_EXEC:    begin w_alu_op = r_op;   w_alu_a = r_a; w_alu_b = r_b;    end
      ST_MAC_MUL: begin w_alu_op = OP_MUL; w_alu_a = r_b; w_alu_b = r_c;    end
      ST_MAC_ADD: begin w_alu_op = OP_ADD; w_alu_a = r_a; w_alu_b = r_prod; end
      default:    ;
    endcase
  end

  ALU24 #(.W(W)) u_alu (
    .i_op (w_alu_op),
    .i_a  (w_alu_a),
    .i_b  (w_alu_b),
    .o_y  (w_alu_y),
    .o_z  (w_alu_z),
    .o_lt (w_alu_lt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_last      <= 1'b1;
      r_prod      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_y     <= '0;
      r_rsp_z     <= 1'b0;
      r_rsp_lt    <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_last  <= req1_ready;
            r_state <= (w_sel_op == OP_MAC) ? ST_MAC_MUL : ST_EXEC;
          end
        end
        ST_MAC_MUL: begin
          r_prod  <= w_alu_y;
          r_state <= ST_MAC_ADD;
        end
        ST_EXEC, ST_MAC_ADD: begin
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_id;
          r_rsp_y     <= w_alu_y;
          r_rsp_z     <= w_alu_z;
          r_rsp_lt    <= w_alu_lt;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_y     = r_rsp_y;
  assign rsp_z     = r_rsp_z;
  assign rsp_lt    = r_rsp_lt;
  assign busy      = !w_idle;

endmodule

// File: tb/tb_alu24_sched.sv
// Self-checking bench for alu24_sched: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_alu24_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [23:0] req0_a = '0, req0_b = '0, req0_c = '0;
  logic [23:0] req1_a = '0, req1_b = '0, req1_c = '0;
  logic        rsp_valid, rsp_id, rsp_z, rsp_lt, busy;
  logic [23:0] rsp_y;

  int pass_cnt = 0;
  int total = 0;
  int cyc = 0;

  alu24_sched #(.W(24)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .rsp_z(rsp_z), .rsp_lt(rsp_lt), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint sx(input logic [23:0] v);
    longint t;
    t = longint'(v);
    if (v[23]) t = t - (longint'(1) << 24);
    return t;
  endfunction

  function automatic void ref_alu(input logic [2:0] op, input logic [23:0] a, b, c,
                                  output logic [23:0] y, output logic lt);
    longint sa, sb, p, r;
    logic [23:0] pw;
    sa = sx(a); sb = sx(b); lt = (sa < sb); r = 0;
    case (op)
      3'd0, 3'd3: r = sa + sb;
      3'd1:       r = sa * sb;
      3'd2, 3'd5: r = sb;
      3'd4:       r = longint'(a | b);
      3'd6:       r = sa >>> b[4:0];
      default: begin
        r = sb * sx(c); pw = r[23:0]; p = sx(pw);
        r = sa + p; lt = (sa < p);
      end
    endcase
    y = r[23:0];
  endfunction

  task automatic drive(input int port, input logic v, input logic [2:0] op,
                       input logic [23:0] a, b, c);
    if (port == 0) begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_c = c; end
    else           begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_c = c; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  // Presents one request, waits (bounded) for accept and response.
  task automatic issue(input int port, input logic [2:0] op, input logic [23:0] a, b, c,
                       output bit acc, output bit rsp, output int lat,
                       output logic [23:0] y, output logic z, lt, id);
    int acyc;
    acc = 0; rsp = 0; lat = 0; y = '0; z = 0; lt = 0; id = 0; acyc = 0;
    drive(port, 1'b1, op, a, b, c);
    for (int k = 0; k < 20 && !acc; k++) begin
      #1;
      if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) begin acc = 1; acyc = cyc; end
      @(posedge clk); #1;
    end
    drive(port, 1'b0, op, a, b, c);
    if (acc) begin
      for (int k = 0; k < 10 && !rsp; k++) begin
        if (rsp_valid) begin
          rsp = 1; lat = cyc - acyc; y = rsp_y; z = rsp_z; lt = rsp_lt; id = rsp_id;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    #1;
    total++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_z, rsp_lt, busy} !== 7'b0)
      $display("FAIL reset_ctl: got %b want 0000000",
               {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_z, rsp_lt, busy});
    else pass_cnt++;
    total++;
    if (rsp_y !== 24'h0) $display("FAIL reset_y: got %h want 000000", rsp_y);
    else pass_cnt++;
    req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed(input string name, input int port, input logic [2:0] op,
                               input logic [23:0] a, b, c, input logic [23:0] ey,
                               input logic ez, elt, input int elat);
    bit acc, rsp; int lat; logic [23:0] y; logic z, lt, id;
    issue(port, op, a, b, c, acc, rsp, lat, y, z, lt, id);
    total++;
    if (!(acc && rsp)) $display("FAIL %s_handshake: acc=%0d rsp=%0d want 1 1", name, acc, rsp);
    else pass_cnt++;
    total++;
    if (y !== ey) $display("FAIL %s_y: got %h want %h", name, y, ey); else pass_cnt++;
    total++;
    if ({z, lt, id} !== {ez, elt, 1'(port)})
      $display("FAIL %s_flags: got z/lt/id %b want %b", name, {z, lt, id}, {ez, elt, 1'(port)});
    else pass_cnt++;
    total++;
    if (lat != elat) $display("FAIL %s_latency: got %0d want %0d", name, lat, elat);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int grants[$]; logic [23:0] exp_y[$], got_y[$]; logic exp_id[$], got_id[$];
    logic [23:0] ry; logic rlt;
    do_reset();
    drive(0, 1'b1, 3'd1, 24'd7, 24'd6, 24'd0);
    drive(1, 1'b1, 3'd4, 24'h0000F0, 24'h00000F, 24'd0);
    for (int k = 0; k < 19; k++) begin
      #1;
      if (k == 14) begin req0_valid = 1'b0; req1_valid = 1'b0; #1; end
      if (req0_ready) begin grants.push_back(0); ref_alu(3'd1, 24'd7, 24'd6, 24'd0, ry, rlt);
        exp_y.push_back(ry); exp_id.push_back(1'b0); end
      if (req1_ready) begin grants.push_back(1); ref_alu(3'd4, 24'hF0, 24'h0F, 24'd0, ry, rlt);
        exp_y.push_back(ry); exp_id.push_back(1'b1); end
      if (rsp_valid) begin got_y.push_back(rsp_y); got_id.push_back(rsp_id); end
      @(posedge clk); #1;
    end
    total++;
    if (grants.size() < 6) $display("FAIL rr_grant_count: got %0d want >=6", grants.size());
    else pass_cnt++;
    foreach (grants[i]) begin
      total++;
      if (grants[i] != i % 2) $display("FAIL rr_grant_order[%0d]: got %0d want %0d", i, grants[i], i % 2);
      else pass_cnt++;
    end
    total++;
    if (got_y.size() != exp_y.size())
      $display("FAIL rr_rsp_count: got %0d want %0d", got_y.size(), exp_y.size());
    else pass_cnt++;
    for (int i = 0; i < got_y.size() && i < exp_y.size(); i++) begin
      total++;
      if (got_y[i] !== exp_y[i] || got_id[i] !== exp_id[i])
        $display("FAIL rr_rsp[%0d]: got %h/%b want %h/%b", i, got_y[i], got_id[i], exp_y[i], exp_id[i]);
      else pass_cnt++;
    end
    total++;
    if (exp_y.size() >= 2 && (exp_y[0] !== 24'h00002A || exp_y[1] !== 24'h0000FF))
      $display("FAIL rr_model_values: got %h %h want 00002a 0000ff", exp_y[0], exp_y[1]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit acc; int seen;
    acc = 0; seen = 0;
    drive(1, 1'b1, 3'd7, 24'd10, 24'd3, 24'hFFFFFC);
    for (int k = 0; k < 10 && !acc; k++) begin
      #1; if (req1_ready) acc = 1;
      @(posedge clk); #1;
    end
    req1_valid = 1'b0;
    total++;
    if (!(acc && busy)) $display("FAIL rmid_in_mac: acc=%0d busy=%0d want 1 1", acc, busy);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_z, rsp_lt, busy} !== 7'b0 || rsp_y !== 24'h0)
      $display("FAIL rmid_outputs: got %b/%h want 0000000/000000",
               {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_z, rsp_lt, busy}, rsp_y);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid) seen++;
      @(posedge clk); #1;
    end
    total++;
    if (seen != 0) $display("FAIL rmid_dropped: got %0d responses want 0", seen);
    else pass_cnt++;
    drive(0, 1'b1, 3'd0, 24'd1, 24'd2, 24'd0);
    drive(1, 1'b1, 3'd0, 24'd3, 24'd4, 24'd0);
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL rmid_first_grant: got %b want 10", {req0_ready, req1_ready});
    else pass_cnt++;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic test_back_to_back();
    logic [23:0] ys[$]; int viol; bit acc0, acc1;
    viol = 0; acc0 = 0; acc1 = 0;
    drive(1, 1'b1, 3'd5, 24'h00ABCD, 24'h123400, 24'd0);
    for (int k = 0; k < 10; k++) begin
      #1;
      if (busy && req0_ready) viol++;
      if (rsp_valid) ys.push_back(rsp_y);
      if (req1_ready) acc1 = 1;
      if (req0_ready) acc0 = 1;
      @(posedge clk); #1;
      if (acc1 && req1_valid) begin
        req1_valid = 1'b0;
        drive(0, 1'b1, 3'd2, 24'h000011, 24'h00007F, 24'd0);
      end
      if (acc0) req0_valid = 1'b0;
    end
    total++;
    if (!(acc0 && acc1)) $display("FAIL b2b_accepts: got %0d %0d want 1 1", acc0, acc1);
    else pass_cnt++;
    total++;
    if (viol != 0) $display("FAIL b2b_ready_while_busy: got %0d want 0", viol);
    else pass_cnt++;
    total++;
    if (ys.size() != 2) $display("FAIL b2b_rsp_count: got %0d want 2", ys.size());
    else pass_cnt++;
    if (ys.size() == 2) begin
      total++;
      if (ys[0] !== 24'h123400 || ys[1] !== 24'h00007F)
        $display("FAIL b2b_values: got %h %h want 123400 00007f", ys[0], ys[1]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random(input int n);
    bit acc, rsp; int lat, port, elat; logic [23:0] y, a, b, c, ey; logic z, lt, id, elt;
    logic [2:0] op;
    for (int i = 0; i < n; i++) begin
      port = $urandom_range(1, 0);
      op = 3'($urandom_range(7, 0));
      a = 24'($urandom); b = 24'($urandom); c = 24'($urandom);
      if (i % 5 == 0) begin a = 24'($urandom_range(40, 0)); b = 24'(0 - a); end
      ref_alu(op, a, b, c, ey, elt);
      elat = (op == 3'd7) ? 3 : 2;
      issue(port, op, a, b, c, acc, rsp, lat, y, z, lt, id);
      total++;
      if (!(acc && rsp) || lat != elat || id !== 1'(port))
        $display("FAIL rand%0d_timing: acc=%0d rsp=%0d lat=%0d id=%b want 1 1 %0d %b",
                 i, acc, rsp, lat, id, elat, 1'(port));
      else pass_cnt++;
      total++;
      if (y !== ey || z !== (ey == 24'h0) || lt !== elt)
        $display("FAIL rand%0d_op%0d: got y=%h z=%b lt=%b want y=%h z=%b lt=%b",
                 i, op, y, z, lt, ey, (ey == 24'h0), elt);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_directed("add_zero", 0, 3'd0, 24'h000005, 24'hFFFFFB, 24'h0, 24'h000000, 1'b1, 1'b0, 2);
    test_directed("mac",      1, 3'd7, 24'd10, 24'd3, 24'hFFFFFC, 24'hFFFFFE, 1'b0, 1'b0, 3);
    test_directed("shr",      0, 3'd6, 24'h800000, 24'h000024, 24'h0, 24'hF80000, 1'b0, 1'b1, 2);
    test_round_robin();
    test_reset_mid();
    test_back_to_back();
    test_random(40);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
